// File: rtl/full_adder.sv
// full_adder: {cout,sum} = a + b + cin with signed overflow, ripple or 4-bit-group
// carry-lookahead core, optionally registered outputs with async active-low reset.

module full_adder_cla_grp #(
    parameter int GW = 4
) (
    input  logic [GW-1:0] a_i,
    input  logic [GW-1:0] b_i,
    input  logic          c_i,
    output logic [GW-1:0] s_o,
    output logic          g_o,
    output logic          p_o
);
    logic [GW-1:0] g, p, c;
    logic          cterm, gterm;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every in-group carry is a flat sum of products over g/p and the group carry-in.
    always_comb begin
        c     = '0;
        cterm = 1'b0;
        c[0]  = c_i;
        for (int k = 1; k < GW; k++) begin
            cterm = c_i;
            for (int m = 0; m < k; m++) cterm = cterm & p[m];
            c[k] = cterm;
            for (int j = 0; j < k; j++) begin
                cterm = g[j];
                for (int m = j + 1; m < k; m++) cterm = cterm & p[m];
                c[k] = c[k] | cterm;
            end
        end
    end

    always_comb begin
        g_o   = 1'b0;
        gterm = 1'b0;
        for (int j = 0; j < GW; j++) begin
            gterm = g[j];
            for (int m = j + 1; m < GW; m++) gterm = gterm & p[m];
            g_o = g_o | gterm;
        end
    end

    assign p_o = &p;
    assign s_o = p ^ c;
endmodule

module full_adder #(
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 0,
    parameter int ARCH    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGRP = (WIDTH + 3) / 4;

    logic [WIDTH-1:0] sum_d;
    logic             cout_d, ovf_d, cmsb;

    if (ARCH == 0) begin : g_ripple
        logic [WIDTH-1:0] rc_sum;
        logic             rc_c;

        always_comb begin
            rc_sum = '0;
            rc_c   = cin;
            for (int i = 0; i < WIDTH; i++) begin
                rc_sum[i] = a[i] ^ b[i] ^ rc_c;
                rc_c      = (a[i] & b[i]) | (a[i] & rc_c) | (b[i] & rc_c);
            end
        end

        assign sum_d  = rc_sum;
        assign cout_d = rc_c;
    end else begin : g_cla
        logic [NGRP-1:0] grp_g, grp_p;
        logic [NGRP:0]   cg;

        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            localparam int GW = (WIDTH - 4 * gi) < 4 ? (WIDTH - 4 * gi) : 4;
            full_adder_cla_grp #(.GW(GW)) u_grp (
                .a_i (a[4*gi +: GW]),
                .b_i (b[4*gi +: GW]),
                .c_i (cg[gi]),
                .s_o (sum_d[4*gi +: GW]),
                .g_o (grp_g[gi]),
                .p_o (grp_p[gi])
            );
        end

        // Group carries ripple from one lookahead group to the next.
        always_comb begin
            cg    = '0;
            cg[0] = cin;
            for (int gi = 0; gi < NGRP; gi++) cg[gi+1] = grp_g[gi] | (grp_p[gi] & cg[gi]);
        end

        assign cout_d = cg[NGRP];
    end

    // Carry into the MSB recovered from the MSB sum bit; equals cin when WIDTH is 1.
    assign cmsb  = sum_d[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    assign ovf_d = cout_d ^ cmsb;

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q, ovf_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end

        assign sum  = sum_q;
        assign cout = cout_q;
        assign ovf  = ovf_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign sum  = sum_d;
        assign cout = cout_d;
        assign ovf  = ovf_d;
    end
endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: combinational 1/8/13-bit instances in both
// architectures plus a registered 4-bit instance, checked against a+b+cin arithmetic.

module tb_full_adder;
    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct packed {
        res_t r1;
        res_t r8;
        res_t r13;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a1 = 0, b1 = 0, c1 = 0, sum1, cout1, ovf1;
    logic [7:0]  a8 = 0, b8 = 0, sum8r, sum8c;
    logic        c8 = 0, cout8r, ovf8r, cout8c, ovf8c;
    logic [12:0] a13 = 0, b13 = 0, sum13r, sum13c;
    logic        c13 = 0, cout13r, ovf13r, cout13c, ovf13c;
    logic [3:0]  a4 = 0, b4 = 0, sum4;
    logic        c4 = 0, cout4, ovf4;

    full_adder u_w1 (.clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(c1),
                     .sum(sum1), .cout(cout1), .ovf(ovf1));
    full_adder #(.WIDTH(8), .ARCH(0)) u_r8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8),
                     .sum(sum8r), .cout(cout8r), .ovf(ovf8r));
    full_adder #(.WIDTH(8), .ARCH(1)) u_c8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8),
                     .sum(sum8c), .cout(cout8c), .ovf(ovf8c));
    full_adder #(.WIDTH(13), .ARCH(0)) u_r13 (.clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .cin(c13),
                     .sum(sum13r), .cout(cout13r), .ovf(ovf13r));
    full_adder #(.WIDTH(13), .ARCH(1)) u_c13 (.clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .cin(c13),
                     .sum(sum13c), .cout(cout13c), .ovf(ovf13c));
    full_adder #(.WIDTH(4), .OUT_REG(1), .ARCH(1)) u_reg (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
                     .cin(c4), .sum(sum4), .cout(cout4), .ovf(ovf4));

    int   checks = 0;
    int   failures = 0;
    exp_t q_c[$];
    res_t q_r[$];
    logic cvld = 1'b0;
    logic rissue = 1'b0;
    logic rvld;
    exp_t me;
    res_t mr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=empty expected=entry t=%0t", nm, $time);
    endtask

    function automatic res_t mk(input logic [63:0] s, input logic c, input logic o);
        res_t r;
        r.s = s;
        r.c = c;
        r.o = o;
        return r;
    endfunction

    // Plain arithmetic reference: (WIDTH+1)-bit sum, overflow from operand/result signs.
    function automatic res_t ref_add(input int w, input logic [63:0] x, input logic [63:0] y,
                                     input logic ci);
        logic [64:0] mask, full;
        res_t r;
        mask = (65'd1 << w) - 65'd1;
        full = ({1'b0, x} & mask) + ({1'b0, y} & mask) + {64'd0, ci};
        r.s = full[63:0] & mask[63:0];
        r.c = full[w];
        r.o = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
        return r;
    endfunction

    task automatic comb_step(input logic [2:0] abc, input res_t e1, input logic [7:0] xa,
                             input logic [7:0] xb, input logic xc, input res_t e8);
        exp_t e;
        @(posedge clk);
        #1;
        {a1, b1, c1} = abc;
        a8 = xa; b8 = xb; c8 = xc;
        a13 = 13'($urandom); b13 = 13'($urandom); c13 = 1'($urandom);
        e.r1  = e1;
        e.r8  = e8;
        e.r13 = ref_add(13, 64'(a13), 64'(b13), c13);
        q_c.push_back(e);
        cvld = 1'b1;
    endtask

    task automatic chk_reg_zero(input string nm);
        chk({nm, "_sum"}, 64'(sum4), 64'd0);
        chk({nm, "_cout"}, 64'(cout4), 64'd0);
        chk({nm, "_ovf"}, 64'(ovf4), 64'd0);
    endtask

    always @(negedge clk) begin
        if (cvld) begin
            if (q_c.size() == 0) note_fail("comb_queue");
            else begin
                me = q_c.pop_front();
                chk("w1_sum", 64'(sum1), me.r1.s);
                chk("w1_cout", 64'(cout1), 64'(me.r1.c));
                chk("w1_ovf", 64'(ovf1), 64'(me.r1.o));
                chk("rc8_sum", 64'(sum8r), me.r8.s);
                chk("rc8_cout", 64'(cout8r), 64'(me.r8.c));
                chk("rc8_ovf", 64'(ovf8r), 64'(me.r8.o));
                chk("cla8_sum", 64'(sum8c), me.r8.s);
                chk("cla8_cout", 64'(cout8c), 64'(me.r8.c));
                chk("cla8_ovf", 64'(ovf8c), 64'(me.r8.o));
                chk("rc13_sum", 64'(sum13r), me.r13.s);
                chk("rc13_cout", 64'(cout13r), 64'(me.r13.c));
                chk("rc13_ovf", 64'(ovf13r), 64'(me.r13.o));
                chk("cla13_sum", 64'(sum13c), me.r13.s);
                chk("cla13_cout", 64'(cout13c), 64'(me.r13.c));
                chk("cla13_ovf", 64'(ovf13c), 64'(me.r13.o));
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rvld <= 1'b0;
        else        rvld <= rissue;
    end

    always @(negedge clk) begin
        if (rvld) begin
            if (q_r.size() == 0) note_fail("reg_queue");
            else begin
                mr = q_r.pop_front();
                chk("reg_sum", 64'(sum4), mr.s);
                chk("reg_cout", 64'(cout4), 64'(mr.c));
                chk("reg_ovf", 64'(ovf4), 64'(mr.o));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tt_s, tt_c, tt_o;
        logic [7:0] ra, rb;
        logic       rc;
        logic [2:0] r1;
        tt_s = 8'b1001_0110;
        tt_c = 8'b1110_1000;
        tt_o = 8'b0100_0010;

        #1 rst_n = 1'b0;
        #1 chk_reg_zero("reset_init");

        // 1-bit truth table against the expected table; wider DUTs see random operands.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            comb_step(3'(i), mk(64'(tt_s[i]), tt_c[i], tt_o[i]), ra, rb, rc,
                      ref_add(8, 64'(ra), 64'(rb), rc));
        end
        comb_step(3'b111, mk(64'd1, 1'b1, 1'b0), 8'hFF, 8'h01, 1'b0, mk(64'h00, 1'b1, 1'b0));
        comb_step(3'b000, mk(64'd0, 1'b0, 1'b0), 8'h7F, 8'h01, 1'b0, mk(64'h80, 1'b0, 1'b1));
        comb_step(3'b111, mk(64'd1, 1'b1, 1'b0), 8'hFF, 8'hFF, 1'b1, mk(64'hFF, 1'b1, 1'b0));
        comb_step(3'b000, mk(64'd0, 1'b0, 1'b0), 8'h00, 8'h00, 1'b0, mk(64'h00, 1'b0, 1'b0));
        comb_step(3'b000, mk(64'd0, 1'b0, 1'b0), 8'h80, 8'h80, 1'b0, mk(64'h00, 1'b1, 1'b1));
        for (int i = 0; i < 10000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            r1 = 3'($urandom);
            comb_step(r1, ref_add(1, 64'(r1[2]), 64'(r1[1]), r1[0]), ra, rb, rc,
                      ref_add(8, 64'(ra), 64'(rb), rc));
        end
        @(posedge clk);
        #1 cvld = 1'b0;

        // Registered instance: outputs stay 0 across edges while reset is held.
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk_reg_zero("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_reg_zero("release_before_edge");
        q_r.push_back(mk(64'h2, 1'b1, 1'b1));
        rissue = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            q_r.push_back(ref_add(4, 64'(a4), 64'(b4), c4));
        end
        @(posedge clk);
        #2;
        a4 = 4'h5; b4 = 4'h5; c4 = 1'b0;
        q_r.push_back(mk(64'hA, 1'b0, 1'b1));
        @(posedge clk);
        #2 rissue = 1'b0;
        @(posedge clk);
        #2;
        // Asynchronous reset between edges while the register holds 4'hA.
        chk("pre_reset_sum", 64'(sum4), 64'hA);
        rst_n = 1'b0;
        #1 chk_reg_zero("async_reset");
        q_r.delete();
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
        @(posedge clk);
        #1 chk_reg_zero("reset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        q_r.push_back(mk(64'h7, 1'b0, 1'b0));
        rissue = 1'b1;
        @(posedge clk);
        #2 rissue = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("comb_queue_drained", 64'(q_c.size()), 64'd0);
        chk("reg_queue_drained", 64'(q_r.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable binary adder: `a + b + cin`, producing `sum`, carry-out `cout` and signed overflow `ovf`.
- Default configuration (`WIDTH`=1, `OUT_REG`=0) is a purely combinational 1-bit full adder, the leaf cell for arithmetic datapaths.
- Optional output register stage and carry-lookahead architecture allow reuse as a pipelined multi-bit adder.

Parameters:
- `WIDTH`, 1, operand/sum width in bits; legal range 1..64.
- `OUT_REG`, 0, 0 = combinational outputs; 1 = outputs registered on `clk`.
- `ARCH`, 0, 0 = ripple-carry; 1 = carry-lookahead in 4-bit groups, with group carries rippled; last group may be partial.

Ports:
- `clk` input 1 rising-edge clock; used only when `OUT_REG`=1.
- `rst_n` input 1 asynchronous active-low reset; used only when `OUT_REG`=1.
- `a` input `WIDTH` operand A, unsigned or two's complement.
- `b` input `WIDTH` operand B.
- `cin` input 1 carry-in, weight 2^0.
- `sum` output `WIDTH` low `WIDTH` bits of `a+b+cin`.
- `cout` output 1 carry-out, bit `WIDTH` of `a+b+cin`.
- `ovf` output 1 signed overflow: `a[MSB]==b[MSB]` and `sum[MSB]!=a[MSB]`.

Behaviour:
- Arithmetic:
  - Full result is `{cout,sum} = a + b + cin`, computed at `WIDTH+1` bits; no truncation beyond that.
  - Per-bit cell: `s_i = a_i ^ b_i ^ c_i`; `c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i`; `c_0 = cin`; `cout = c_WIDTH`.
  - `ARCH`=1: per bit `g_i = a_i&b_i`, `p_i = a_i^b_i`. Group carries come from the standard lookahead expressions. Results must be bit-identical to `ARCH`=0 for all inputs.
  - `ovf` equals `c_WIDTH ^ c_(WIDTH-1)`. For `WIDTH`=1, `c_0 = cin`, so `ovf = cout ^ cin`.
- `OUT_REG`=0:
  - Outputs are pure combinational functions of `a`, `b`, `cin`; no state.
  - `clk` and `rst_n` are ignored and may be left unconnected.
  - Outputs settle within the same delta/time step as an input change. No latches are inferred.
  - Any X/Z on an input propagates to the affected outputs only.
- `OUT_REG`=1:
  - `sum`, `cout`, `ovf` are flops loaded every rising `clk` edge with the combinational result of the current inputs. Latency is 1 cycle; throughput is one result per cycle; there is no enable.
  - `rst_n` low forces `sum`=0, `cout`=0, `ovf`=0 immediately and asynchronously, without waiting for a clock edge.
  - Outputs hold 0 while `rst_n` is low, regardless of `clk`.
  - After `rst_n` deasserts, the first rising edge loads the current result.
  - Reset asserted mid-stream discards the in-flight result. Inputs are not registered; the first post-reset edge samples whatever the inputs are at that edge.
- Boundary conditions:
  - `a` = `b` = all-ones, `cin`=1: `sum` = all-ones, `cout`=1.
  - `a` = `b` = 0, `cin`=0: all outputs 0.
  - Wrap-around beyond `WIDTH` bits is reported only via `cout`.
- Constraints:
  - No internal clock gating.
  - Reset applies only to output flops; there are no other registers.

Test Plan:
- Exhaustive 1-bit truth table, `WIDTH`=1, `OUT_REG`=0, stepping (`a`,`b`,`cin`) 000..111 every 10 ns:
  - (`sum`,`cout`) = 00,10,10,01,10,01,01,11.
  - `ovf` = 0,1,0,0,0,0,1,0.
- `WIDTH`=8, `ARCH`=0 and `ARCH`=1:
  - `a`=8'hFF, `b`=8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1, `ovf`=0.
  - `a`=8'h7F, `b`=8'h01, `cin`=0 -> `sum`=8'h80, `cout`=0, `ovf`=1.
- `WIDTH`=8, random 10000 vectors comparing `ARCH`=0 vs `ARCH`=1 vs a behavioural `a+b+cin` reference -> zero mismatches.
- `OUT_REG`=1, `WIDTH`=4:
  - Hold `rst_n`=0 -> outputs 0 with toggling `clk`.
  - Release `rst_n`, then `a`=4'h9, `b`=4'h8, `cin`=1 -> one edge later `sum`=4'h2, `cout`=1, `ovf`=1.
- `OUT_REG`=1, assert `rst_n`=0 between clock edges while `sum`=4'hA -> outputs go to 0 at once, before any edge. Deassert with `a`=3, `b`=4, `cin`=0 -> next edge `sum`=4'h7, `cout`=0, `ovf`=0.
